// File: rtl/triangle_streamer.sv
`timescale 1ns/1ps
// Streams a triangle count header followed by fixed-size triangle records,
// least significant byte first, to a byte-wide UART transmitter.
module triangle_streamer #(
    parameter int TRI_BYTES = 18,
    parameter int CNT_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      num_triangles,
    output logic                   tri_rd,
    output logic [ADDR_W-1:0]      tri_addr,
    input  logic [TRI_BYTES*8-1:0] tri_rdata,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   done
);

    localparam int SR_W = TRI_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        FETCH,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [4:0]        bcnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] idx_next;
    logic              hdr;

    assign idx_next = idx + ADDR_W'(1);
    assign tx_data  = sr[7:0];
    assign tri_addr = idx;

    // Pulse outputs are registered alongside the state so each one is high
    // exactly for the cycle spent in its state; abort overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            bcnt   <= '0;
            idx    <= '0;
            n      <= '0;
            hdr    <= 1'b0;
            tri_rd <= 1'b0;
            trmt   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            tri_rd <= 1'b0;
            trmt   <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            n     <= num_triangles;
                            sr    <= SR_W'(num_triangles);
                            bcnt  <= 5'(CNT_BYTES);
                            hdr   <= 1'b1;
                            idx   <= '0;
                            state <= SEND;
                            trmt  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    SEND: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (tx_done) begin
                            sr   <= sr >> 8;
                            bcnt <= bcnt - 5'd1;
                            if (bcnt != 5'd1) begin
                                state <= SEND;
                                trmt  <= 1'b1;
                            end else if (hdr) begin
                                hdr <= 1'b0;
                                if (n == '0) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state  <= FETCH;
                                    tri_rd <= 1'b1;
                                end
                            end else begin
                                idx <= idx_next;
                                if (idx_next == n) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state  <= FETCH;
                                    tri_rd <= 1'b1;
                                end
                            end
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        sr    <= tri_rdata;
                        bcnt  <= 5'(TRI_BYTES);
                        state <= SEND;
                        trmt  <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
